student_or_accum: RTL
=====================

STUDENT_OR_ACCUM -- requirements
Module: student_or_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width in bits (>=2).
REQ-002 SHALL have parameter MAX_BEATS, default 8: beats counted per frame before saturation (>=1).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port in_data  input  WIDTH: input word.
REQ-006 SHALL have port in_valid  input  1: in_data is valid this cycle.
REQ-007 SHALL have port in_last  input  1: current beat ends the frame; qualified by in_valid.
REQ-008 SHALL have port in_ready  output  1: block accepts a beat this cycle.
REQ-009 SHALL have port out_data  output  WIDTH: bitwise OR of all beats in the frame.
REQ-010 SHALL have port out_any  output  1: OR-reduction of out_data.
REQ-011 SHALL have port out_beats  output  $clog2(MAX_BEATS+1): accepted beat count, saturating.
REQ-012 SHALL have port out_overflow  output  1: frame had more than MAX_BEATS beats.
REQ-013 SHALL have port out_valid  output  1: result is valid.
REQ-014 SHALL have port out_ready  input  1: consumer takes the result.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM and DONE; a beat is accepted when in_valid && in_ready.
REQ-016 SHALL, in IDLE, drive in_ready=1; on accept: acc<=in_data, cnt<=1, ovf<=0; next state DONE if in_last, else ACCUM.
REQ-017 SHALL, in ACCUM, drive in_ready=1; on accept: acc<=acc|in_data, cnt<=cnt+1 saturating at MAX_BEATS; next state DONE if in_last.
REQ-018 SHALL set ovf on any ACCUM accept while cnt==MAX_BEATS; acc keeps OR-ing every beat regardless of overflow.
REQ-019 SHALL leave state unchanged in IDLE/ACCUM on cycles with in_valid=0; gaps are legal.
REQ-020 SHALL, in DONE, drive in_ready=0 and out_valid=1; in_valid is ignored.
REQ-021 SHALL hold out_data/out_any/out_beats/out_overflow stable while out_valid && !out_ready.
REQ-022 SHALL, in DONE with out_ready=1, clear acc, cnt and ovf and go to IDLE on the next edge.
REQ-023 SHALL assert out_valid exactly one cycle after the in_last beat is accepted (latency 1).
REQ-024 SHALL treat a single beat with in_last in IDLE as a complete frame (out_beats=1).
REQ-025 SHALL drive out_data, out_beats, out_overflow and out_any directly from registers (out_any through the reduction sub-module), with no combinational input-to-output path except in_ready from state.

Reset
REQ-026 SHALL, while reset=1 at a clock edge, enter IDLE with acc=0, cnt=0, ovf=0, out_valid=0 and in_ready=1 after the edge, overriding any simultaneous beat.
REQ-027 SHALL discard any partial frame or pending result on reset, with no output pulse.

Structure
REQ-028 SHALL place state encodings in shared package student_or_pkg (IDLE=2'b00, ACCUM=2'b01, DONE=2'b10); the encoding 2'b11 SHALL recover to IDLE.
REQ-029 SHALL instantiate sub-module student_or_nway (combinational WIDTH-input OR reduction) to produce out_any.

Verification (WIDTH=16, MAX_BEATS=4)
REQ-030 SHALL cover: one beat 16'h0000 with in_last -> next cycle out_valid=1, out_data=16'h0000, out_any=0, out_beats=1, out_overflow=0.
REQ-031 SHALL cover: beats 16'h0001, 16'h0100, 16'h8000 (last), idle cycles between beats -> out_data=16'h8101, out_any=1, out_beats=3.
REQ-032 SHALL cover: six beats 16'h0001<<i, i=0..5 -> out_data=16'h003F, out_beats=4, out_overflow=1.
REQ-033 SHALL cover: out_ready=0 for 5 cycles in DONE while in_valid=1 -> in_ready=0, outputs stable, beats ignored; out_ready=1 -> IDLE next cycle.
REQ-034 SHALL cover: reset asserted after two accepted beats -> next cycle state IDLE, out_valid=0; the following frame 16'h0002 (last) -> out_data=16'h0002, out_beats=1.

Source files
------------

// File: rtl/student_or_pkg.sv
// Shared definitions for the OR-accumulator slice: FSM state encodings.
package student_or_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/student_or_nway.sv
// Combinational WIDTH-input OR reduction.
module student_or_nway #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in_data,
    output logic             out_any
);

    assign out_any = |in_data;

endmodule

// File: rtl/student_or_accum.sv
// Frame OR-accumulator: ORs every beat of a frame, counts beats (saturating),
// flags overflow, and holds the result until the consumer takes it.
module student_or_accum
    import student_or_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_BEATS = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           in_valid,
    input  logic                           in_last,
    output logic                           in_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic                           out_any,
    output logic [$clog2(MAX_BEATS+1)-1:0] out_beats,
    output logic                           out_overflow,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

    state_t          state, state_nx;
    logic [WIDTH-1:0] acc, acc_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             ovf, ovf_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            ovf   <= ovf_nx;
        end
    end

    // in_ready is 1 in both accepting states, so in_valid alone qualifies a beat there.
    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        cnt_nx    = cnt;
        ovf_nx    = ovf;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_nx   = in_data;
                    cnt_nx   = CW'(1);
                    ovf_nx   = 1'b0;
                    state_nx = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_nx = acc | in_data;
                    if (cnt == MAX_CNT) begin
                        ovf_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                    if (in_last) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_nx   = '0;
                    cnt_nx   = '0;
                    ovf_nx   = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: begin
                // Unused encoding 2'b11 falls back to a clean IDLE.
                acc_nx   = '0;
                cnt_nx   = '0;
                ovf_nx   = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    assign out_data     = acc;
    assign out_beats    = cnt;
    assign out_overflow = ovf;

    student_or_nway #(
        .WIDTH (WIDTH)
    ) u_nway (
        .in_data (acc),
        .out_any (out_any)
    );

endmodule
